// File: rtl/hash_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hash_pkg                                                  |
// | Brief    : Shared types, constants and mix-select helper for the     |
// |            multi-round byte hash engine.                             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package hash_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_state_e;

  // Boolean mixing function applied in a round
  typedef enum logic [1:0] {
    CHOOSE = 2'd0,
    MAJ    = 2'd1,
    PARITY = 2'd2
  } mix_sel_e;

  // Round index width: covers NUM_ROUNDS up to 256 (indices 0..255)
  localparam int RIDX_W = 8;

  // State loaded at reset and after every digest handoff
  localparam logic [31:0] DEFAULT_IV = 32'h0000_0000;

  // The mixing function repeats with period 8 over the round index
  function automatic mix_sel_e mix_sel(input logic [2:0] r_mod8);
    case (r_mod8)
      3'd0, 3'd1, 3'd2: return CHOOSE;
      3'd3, 3'd4:       return MAJ;
      default:          return PARITY;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hash_if                                                   |
// | Brief    : Lane input stream and digest output handshake bundle.     |
// |            master = message source / digest consumer side,           |
// |            slave  = hash engine side.                                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface hash_if #(
  parameter int W = 8
);
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] digest;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, digest, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, digest, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/hash_round_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hash_round_core                                           |
// | Brief    : One combinational mixing round over four W-bit lanes:     |
// |            mix mux, modular add with the lane byte, left rotate by   |
// |            (round mod W), then lane shuffle.                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hash_round_core
  import hash_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [4*W-1:0]    state_in,
  input  logic [W-1:0]      lane_byte,
  input  logic [RIDX_W-1:0] round_idx,
  output logic [4*W-1:0]    state_out
);

  // Lane width as a round-index-wide value for the rotate-amount modulo
  localparam logic [RIDX_W-1:0] W_MOD = RIDX_W'(W);

  logic [W-1:0]      a, b, c, d;
  logic [W-1:0]      mix;
  logic [W-1:0]      m;
  logic [W-1:0]      rot;
  logic [RIDX_W-1:0] shamt;
  logic [RIDX_W-1:0] rshamt;
  mix_sel_e          sel;

  assign {d, c, b, a} = state_in;
  assign sel          = mix_sel(round_idx[2:0]);

  // Select the boolean mixing function for this round
  always_comb begin
    mix = '0;
    case (sel)
      CHOOSE:  mix = (c & b) | (~b & d);
      MAJ:     mix = (c & b) | (b & d) | (c & d);
      default: mix = b ^ c ^ d;
    endcase
  end

  // Carries beyond W bits are dropped by the W-bit result
  assign m = mix + a + lane_byte;

  // Rotate left; a zero amount shifts the right term by W, which yields 0
  assign shamt  = round_idx % W_MOD;
  assign rshamt = W_MOD - shamt;
  assign rot    = (m << shamt) | (m >> rshamt);

  assign state_out = {c, b, rot, d};

endmodule
`default_nettype wire

// File: rtl/hash_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hash_engine                                               |
// | Brief    : Sequential multi-round byte hash. Absorbs one lane per    |
// |            NUM_ROUNDS+1 cycles and holds the final digest until the  |
// |            consumer accepts it, then reloads IV.                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hash_engine
  import hash_pkg::*;
#(
  parameter int             W          = 8,
  parameter int             NUM_ROUNDS = 8,
  parameter logic [4*W-1:0] IV         = (4*W)'(DEFAULT_IV)
) (
  input  logic clk,
  input  logic reset,
  hash_if.slave bus
);

  localparam int               CNT_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

  fsm_state_e        fsm_state;
  logic [4*W-1:0]    hash_state;
  logic [4*W-1:0]    next_state;
  logic [CNT_W-1:0]  round_cnt;
  logic [RIDX_W-1:0] round_idx;
  logic [W-1:0]      lane;
  logic              last_flag;
  logic              in_ready_q;
  logic              out_valid_q;

  assign round_idx = RIDX_W'(round_cnt);

  hash_round_core #(
    .W (W)
  ) u_round_core (
    .state_in  (hash_state),
    .lane_byte (lane),
    .round_idx (round_idx),
    .state_out (next_state)
  );

  // The state register doubles as the digest; it only changes in ROUND,
  // so it is stable for the whole time DONE is held.
  assign bus.digest    = hash_state;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Control FSM with lane latch, round counter and registered handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state   <= IDLE;
      hash_state  <= IV;
      round_cnt   <= '0;
      lane        <= '0;
      last_flag   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            lane       <= bus.in_data;
            last_flag  <= bus.in_last;
            round_cnt  <= '0;
            in_ready_q <= 1'b0;
            fsm_state  <= ROUND;
          end
        end
        ROUND: begin
          hash_state <= next_state;
          if (round_cnt == LAST_CNT) begin
            // Counter parks at zero rather than wrapping past the last round
            round_cnt <= '0;
            if (last_flag) begin
              out_valid_q <= 1'b1;
              fsm_state   <= DONE;
            end else begin
              in_ready_q <= 1'b1;
              fsm_state  <= IDLE;
            end
          end else begin
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            hash_state  <= IV;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_state   <= IDLE;
          end
        end
        default: begin
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hash_engine.md
Name: hash_engine

Overview:
Sequential, parametrised multi-round byte hash. Absorbs a message byte-by-byte over a valid/ready stream and applies NUM_ROUNDS mixing rounds per byte, one round per clock. Presents the final STATE_W-bit digest on a held valid/ready output. Sits between the message source (FSM or FIFO) and the digest consumer/comparator.

Parameters:
W, 8, lane width in bits; state is 4 lanes {d,c,b,a}, STATE_W = 4*W
NUM_ROUNDS, 8, rounds applied per input byte (1..256)
IV, 32'h0000_0000, state loaded at reset and after each digest handoff (width 4*W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  W  message lane
in_last  in  1  marks final lane of the message
in_valid  in  1  source has a lane
in_ready  out  1  engine can accept a lane
digest  out  4*W  final state; valid only while out_valid
out_valid  out  1  digest available
out_ready  in  1  consumer takes digest

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, state=IV, round_cnt=0, latched byte=0, last flag=0, in_ready=1, out_valid=0, digest=IV.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch in_data and in_last, round_cnt<=0, go ROUND.
- ROUND: in_ready=0. Each cycle state <= round_fn(state, latched byte, round_cnt); round_cnt++. After round NUM_ROUNDS-1: go DONE if the latched last flag is set, else IDLE.
- DONE: out_valid=1, digest=state, held stable until out_ready. On out_valid&out_ready: state<=IV, go IDLE. in_ready=0 in DONE.
- Throughput: one lane per NUM_ROUNDS+1 cycles. Digest out_valid rises NUM_ROUNDS+1 cycles after the last-lane handshake.
- Round function, with round index r and lanes {d,c,b,a}=state:
  - r mod 8 in {0,1,2}: mix=(c&b)|(~b&d) (choose).
  - r mod 8 in {3,4}: mix=(c&b)|(b&d)|(c&d) (majority).
  - otherwise: mix=b^c^d (parity).
  - m = (mix + a + byte) mod 2^W, carries discarded.
  - rotate m left by (r mod W).
  - new state={c,b,rot(m),d}.
- in_valid while in_ready=0 is ignored. The source must hold data until the handshake.
- A zero-length message is not supported; every message has at least one lane with in_last=1.
- in_last=1 on every lane is legal: each lane becomes a one-lane message from IV.
- reset mid-ROUND or mid-DONE aborts immediately: digest is discarded and state returns to IV.
- round_cnt width is clog2(NUM_ROUNDS) (min 1). It compares against NUM_ROUNDS-1 and never wraps past it.

Decomposition:
- Package hash_pkg: FSM state enum (IDLE/ROUND/DONE), mix-select encoding (CHOOSE/MAJ/PARITY), helper function mapping round index to mix-select, default IV constant.
- Sub-module hash_round_core: purely combinational round with parameter W and a runtime round-index input. It contains the mix mux, the adder and a left rotator by (r mod W).
- hash_engine holds the FSM, counter, lane latch and state register.

Test Plan:
- W=8, NUM_ROUNDS=1, IV=0: one lane 0x01, last=1 -> out_valid 2 cycles after handshake, digest=32'h0000_0100.
- W=8, NUM_ROUNDS=2, IV=0: one lane 0x01, last=1 -> digest=32'h0001_0200; in_ready=0 for exactly 3 cycles until digest accepted.
- Default params, lane 0x00, IV=0 -> digest=32'h0000_0000. Hold out_ready=0 for 10 cycles -> digest and out_valid stable, in_ready=0.
- Default params, 3-lane message with back-to-back in_valid -> handshakes spaced 9 cycles apart. Digest matches the reference-model value and is followed by an IV reload; a second identical message yields the identical digest.
- Assert reset during ROUND of lane 2 -> outputs return to reset values within the same cycle. Replaying the full message after release gives the same digest as an uninterrupted run.
- W=16, NUM_ROUNDS=12 with random messages and random out_ready stalls -> every digest equals the bench's software model, and there are no lost or duplicated lanes.
